multicycle_core: RTL and testbench
==================================

# multicycle_core

Parametrised multi-cycle successor to the single-cycle processor top. It executes the same MIPS-subset ISA through a state machine that reuses one ALU and one unified memory port per instruction. It talks to a variable-latency memory through a req/ready handshake, can be paused at instruction boundaries, and traps illegal opcodes into a sticky halt state. Register file, ALU, ALU control and sign extension are internal to the block.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- ADDR_W, 32: width of mem_addr (16..32); the byte address is truncated to its low ADDR_W bits.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  run enable; sampled only in FETCH before a request is issued.
- mem_req  output  1  memory access request.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  output  ADDR_W  byte address, word-aligned.
- mem_wdata  output  32  store data.
- mem_rdata  input  32  read data; valid in the cycle mem_ready=1.
- mem_ready  input  1  access completes in this cycle.
- retire  output  1  one-cycle pulse in the last cycle of each completed instruction.
- halted  output  1  sticky; set on an illegal instruction.
- pc_out  output  32  current architectural PC.

## Operation
- State machine states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - If en=0, mem_req=0 and the block stays in FETCH.
  - Otherwise mem_req=1, mem_we=0, mem_addr=PC.
  - When mem_ready=1: IR<=mem_rdata, PC<=PC+4, go to DECODE.
- DECODE:
  - A<=R[rs], B<=R[rt].
  - ALUOut<=PC+(sext(imm16)<<2), giving the branch target.
  - Unknown opcode, or R-type with unknown funct, goes to HALT.
- EXEC:
  - R-type: ALUOut<=A op B, then go to WB.
  - addi: ALUOut<=A+sext(imm), then go to WB.
  - lw/sw: ALUOut<=A+sext(imm), then go to MEM.
  - beq: if A==B, PC<=ALUOut; retire, then go to FETCH.
  - j: PC<={PC[31:28],imm26,2'b00}; retire, then go to FETCH.
- MEM:
  - mem_req=1, mem_addr=ALUOut[ADDR_W-1:0], mem_we=(sw), mem_wdata=B.
  - On mem_ready: lw latches MDR<=mem_rdata and goes to WB; sw retires and goes to FETCH.
- WB:
  - R-type writes R[rd]<=ALUOut.
  - addi writes R[rt]<=ALUOut.
  - lw writes R[rt]<=MDR.
  - Retire, then go to FETCH.
- HALT: halted=1 and mem_req=0 forever; only rst exits.
- Opcodes:
  - R-type 0x00 with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- Arithmetic rules:
  - 32-bit, wrap-around, no overflow trap.
  - slt is signed and yields 0 or 1.
  - Immediates are sign-extended.
- R0 reads 0; writes to R0 are discarded.

## Timing
- Reset: while rst=1, outputs are forced combinationally to mem_req=0, mem_we=0, retire=0, halted=0, pc_out=RESET_PC. On the clock edge, state<=FETCH, PC<=RESET_PC, R1..R31<=0.
- First fetch request: the cycle after rst deasserts, if en=1.
- Memory handshake:
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1 and mem_ready=0.
  - The transfer completes in the cycle with mem_req=1 and mem_ready=1 (zero-wait allowed).
  - mem_req drops or moves to the next access the following cycle.
  - mem_ready while mem_req=0 is ignored.
- Cycle counts with zero wait states:
  - beq and j: 3 cycles.
  - R-type, addi and sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1 to the owning FETCH or MEM state.
- en=0 never interrupts an instruction; it takes effect only at the next FETCH. An outstanding fetch is not cancelled.
- rst mid-access: the request is abandoned the same cycle (mem_req=0); no register or PC update from that access.
- pc_out updates on the edge leaving FETCH and, for taken beq or j, on the edge leaving EXEC.

## Test plan
- Reset and first fetch: RESET_PC=0x100; release rst with en=1, mem_ready tied 1 → mem_req=1 with mem_addr=0x100 on the first post-reset cycle; retire pulses 4 cycles later for `add $3,$1,$2` with R1=5, R2=7 → R3=12.
- Load/store with wait states: `sw $1,8($0)` then `lw $4,8($0)`, mem_ready delayed 3 cycles per access → mem_we=1, addr 0x8, data held stable through the wait; R4 equals R1; lw takes 5+6 cycles.
- Branch and jump: `beq $1,$1,-2` at 0x10 → PC=0x0C. Not-taken beq → PC=0x14. `j 0x40` at 0x20 → PC=0x100.
- ALU edges: 0x7FFFFFFF+1 → 0x80000000 with no trap. `slt` with -1 vs 1 → 1. `addi $0,$0,5` → R0 stays 0.
- Illegal instruction: opcode 0x3F → halted=1 after DECODE, mem_req stays 0 for 20 cycles, no retire; rst clears halted.
- Pause and reset: en=0 during WB → next FETCH issues no request until en=1. rst asserted in MEM of an sw awaiting ready → mem_req=0 that cycle, PC=RESET_PC, no write observed.

Source files
------------

// File: rtl/multicycle_core.sv
// Multi-cycle MIPS-subset core: one shared ALU and one unified memory port,
// a req/ready memory handshake, run-enable at instruction boundaries and a sticky illegal-op halt.
module multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic              halted,
    output logic [31:0]       pc_out
);
    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24;
    localparam logic [5:0] F_OR = 6'h25, F_SLT = 6'h2A;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    state_t      r_state, w_next;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_alu, r_mdr;
    logic [31:0] r_rf [0:31];
    logic        r_fetch_pend;

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_wr_idx;
    logic [31:0] w_sext, w_rs_val, w_rt_val;
    logic        w_is_r, w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_is_j, w_legal;
    alu_op_t     w_alu_op;
    logic [31:0] w_alu_a, w_alu_b, w_alu_y;
    logic        w_req, w_we, w_retire;
    logic [ADDR_W-1:0] w_addr;

    assign w_op      = r_ir[31:26];
    assign w_rs      = r_ir[25:21];
    assign w_rt      = r_ir[20:16];
    assign w_rd      = r_ir[15:11];
    assign w_funct   = r_ir[5:0];
    assign w_sext    = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_is_r    = (w_op == OP_R);
    assign w_is_addi = (w_op == OP_ADDI);
    assign w_is_lw   = (w_op == OP_LW);
    assign w_is_sw   = (w_op == OP_SW);
    assign w_is_beq  = (w_op == OP_BEQ);
    assign w_is_j    = (w_op == OP_J);
    assign w_legal   = (w_is_r && (w_funct == F_ADD || w_funct == F_SUB || w_funct == F_AND ||
                                   w_funct == F_OR  || w_funct == F_SLT)) ||
                       w_is_addi || w_is_lw || w_is_sw || w_is_beq || w_is_j;
    assign w_rs_val  = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
    assign w_rt_val  = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];
    assign w_wr_idx  = w_is_r ? w_rd : w_rt;

    // The single ALU does PC+4 in FETCH, the branch target in DECODE and the datapath op in EXEC.
    always_comb begin
        w_alu_a  = r_pc;
        w_alu_b  = 32'd4;
        w_alu_op = ALU_ADD;
        case (r_state)
            S_DECODE: w_alu_b = {w_sext[29:0], 2'b00};
            S_EXEC: begin
                w_alu_a = r_a;
                if (w_is_r) begin
                    w_alu_b = r_b;
                    case (w_funct)
                        F_SUB:   w_alu_op = ALU_SUB;
                        F_AND:   w_alu_op = ALU_AND;
                        F_OR:    w_alu_op = ALU_OR;
                        F_SLT:   w_alu_op = ALU_SLT;
                        default: w_alu_op = ALU_ADD;
                    endcase
                end else if (w_is_beq) begin
                    w_alu_b  = r_b;
                    w_alu_op = ALU_SUB;
                end else begin
                    w_alu_b = w_sext;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (w_alu_op)
            ALU_SUB: w_alu_y = w_alu_a - w_alu_b;
            ALU_AND: w_alu_y = w_alu_a & w_alu_b;
            ALU_OR:  w_alu_y = w_alu_a | w_alu_b;
            ALU_SLT: w_alu_y = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
            default: w_alu_y = w_alu_a + w_alu_b;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_req    = 1'b0;
        w_we     = 1'b0;
        w_addr   = r_pc[ADDR_W-1:0];
        w_retire = 1'b0;
        case (r_state)
            S_FETCH: begin
                // A fetch already on the bus is finished even if en drops meanwhile.
                w_req = en || r_fetch_pend;
                if (w_req && mem_ready) w_next = S_DECODE;
            end
            S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (w_is_r || w_is_addi) begin
                    w_next = S_WB;
                end else if (w_is_lw || w_is_sw) begin
                    w_next = S_MEM;
                end else begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_MEM: begin
                w_req  = 1'b1;
                w_we   = w_is_sw;
                w_addr = r_alu[ADDR_W-1:0];
                if (mem_ready) begin
                    w_retire = w_is_sw;
                    w_next   = w_is_sw ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            default: w_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_fetch_pend <= 1'b0;
            for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
        end else begin
            r_state      <= w_next;
            r_fetch_pend <= (r_state == S_FETCH) && w_req && !mem_ready;
            case (r_state)
                S_FETCH: if (w_req && mem_ready) begin
                    r_ir <= mem_rdata;
                    r_pc <= w_alu_y;
                end
                S_DECODE: begin
                    r_a   <= w_rs_val;
                    r_b   <= w_rt_val;
                    r_alu <= w_alu_y;
                end
                S_EXEC: begin
                    if (w_is_r || w_is_addi || w_is_lw || w_is_sw) r_alu <= w_alu_y;
                    if (w_is_beq && w_alu_y == 32'd0) r_pc <= r_alu;
                    if (w_is_j) r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                end
                S_MEM: if (mem_ready && w_is_lw) r_mdr <= mem_rdata;
                S_WB: if (w_wr_idx != 5'd0) r_rf[w_wr_idx] <= w_is_lw ? r_mdr : r_alu;
                default: ;
            endcase
        end
    end

    assign mem_req   = w_req && !rst;
    assign mem_we    = w_we && !rst;
    assign mem_addr  = w_addr;
    assign mem_wdata = r_b;
    assign retire    = w_retire && !rst;
    assign halted    = (r_state == S_HALT) && !rst;
    assign pc_out    = rst ? RESET_PC : r_pc;
endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: variable-latency memory model, store scoreboard,
// ALU vector table and hand-written sequences for branches, waits, halt, pause and reset.
module tb_multicycle_core;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] ILL = 32'hFC00_0000;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b1;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

    multicycle_core #(.RESET_PC(RPC), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .en(en),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .retire(retire), .halted(halted), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    // Memory model: all array/log updates live in this one process.
    logic [31:0] mem [0:1023];
    logic        clr = 1'b0, ld_en = 1'b0;
    logic [31:0] ld_a = 32'd0, ld_d = 32'd0;
    int          lat = 0, wcnt = 0, wr_cnt = 0, stab_err = 0;
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    logic        pend = 1'b0, s_we = 1'b0;
    logic [31:0] s_addr = 32'd0, s_wdata = 32'd0;

    assign mem_ready = mem_req && (wcnt >= lat);
    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
            wr_cnt   <= 0;
            stab_err <= 0;
        end else begin
            if (ld_en) mem[ld_a[11:2]] <= ld_d;
            if (mem_req && mem_ready && mem_we) begin
                mem[mem_addr[11:2]]  <= mem_wdata;
                wr_addr[wr_cnt[5:0]] <= mem_addr;
                wr_data[wr_cnt[5:0]] <= mem_wdata;
                wr_cnt               <= wr_cnt + 1;
            end
            if (pend && mem_req && (mem_addr != s_addr || mem_we != s_we || mem_wdata != s_wdata))
                stab_err <= stab_err + 1;
        end
        wcnt    <= (!mem_req || mem_ready) ? 0 : wcnt + 1;
        pend    <= mem_req && !mem_ready;
        s_addr  <= mem_addr;
        s_we    <= mem_we;
        s_wdata <= mem_wdata;
    end

    int          checks = 0, failures = 0;
    logic [31:0] exp_a[$], exp_d[$];
    int          ret_cyc[$];
    logic [31:0] ret_pc[$];
    int          halt_cyc;
    logic        run_done, first_req;
    logic [31:0] first_addr, pa;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [0:8];

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {6'h02, t};
    endfunction
    function automatic int rc(input int i);
        return (i < ret_cyc.size()) ? ret_cyc[i] : -1000;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask
    task automatic check1(input string nm, input logic got, input logic exp);
        check(nm, {31'd0, got}, {31'd0, exp});
    endtask

    task automatic begin_test(input int l);
        rst = 1'b1; en = 1'b1; lat = l; clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        pa = RPC;
    endtask
    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        ld_a = a; ld_d = d; ld_en = 1'b1;
        @(posedge clk); #1 ld_en = 1'b0;
    endtask
    task automatic put(input logic [31:0] w);
        poke(pa, w);
        pa = pa + 32'd4;
    endtask
    task automatic expect_store(input logic [31:0] a, input logic [31:0] d);
        exp_a.push_back(a);
        exp_d.push_back(d);
    endtask
    task automatic go();
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic run(input int maxc, input int maxret);
        int   n;
        logic prev;
        n = 0; prev = 1'b0;
        ret_cyc.delete(); ret_pc.delete(); halt_cyc = 0; run_done = 1'b0;
        while (n < maxc && !run_done) begin
            @(negedge clk);
            n++;
            if (n == 1) begin first_req = mem_req; first_addr = mem_addr; end
            if (prev) ret_pc.push_back(pc_out);
            prev = retire;
            if (retire) ret_cyc.push_back(n);
            if (halted) begin
                halt_cyc = n; run_done = 1'b1;
            end else if (maxret > 0 && ret_pc.size() >= maxret) begin
                run_done = 1'b1;
            end
        end
        check1("run_done", run_done, 1'b1);
    endtask

    task automatic sb_check(input string nm);
        int k;
        k = 0;
        while (exp_a.size() > 0) begin
            logic [31:0] ea, ed;
            ea = exp_a.pop_front();
            ed = exp_d.pop_front();
            if (k < wr_cnt) begin
                check({nm, "_addr"}, wr_addr[k], ea);
                check({nm, "_data"}, wr_data[k], ed);
            end else begin
                check({nm, "_missing"}, 32'(wr_cnt), 32'(k + 1));
            end
            k++;
        end
        check({nm, "_nwrites"}, 32'(wr_cnt), 32'(k));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idle;
        logic [31:0] exp_pcs [0:5];

        vecs[0] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h20), 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        vecs[1] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h20), 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[2] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h22), 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE};
        vecs[3] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h24), 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200};
        vecs[4] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h25), 32'hF0F0_0000, 32'h0000_1234, 32'hF0F0_1234};
        vecs[5] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h2A), 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[6] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h2A), 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h2A), 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
        vecs[8] = '{enc_i(6'h08, 5'd1, 5'd3, 16'hFFFD), 32'h0000_0001, 32'h0, 32'hFFFF_FFFE};

        // Reset state, first fetch and add timing.
        begin_test(0);
        put(enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(enc_i(6'h08, 5'd0, 5'd2, 16'd7));
        put(enc_r(5'd1, 5'd2, 5'd3, 6'h20));
        put(enc_i(6'h2B, 5'd0, 5'd3, 16'h0300));
        put(ILL);
        expect_store(32'h300, 32'd12);
        @(negedge clk);
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check1("rst_retire", retire, 1'b0);
        check1("rst_halted", halted, 1'b0);
        check("rst_pc_out", pc_out, RPC);
        go();
        run(200, 0);
        check1("first_req", first_req, 1'b1);
        check("first_addr", first_addr, RPC);
        check("addi_retire_cyc", 32'(rc(0)), 32'd4);
        check("add_cycles", 32'(rc(2) - rc(1)), 32'd4);
        sb_check("add");

        // Store then load with 3 wait states per access.
        begin_test(3);
        put(enc_i(6'h08, 5'd0, 5'd1, 16'h0055));
        put(enc_i(6'h2B, 5'd0, 5'd1, 16'h0008));
        put(enc_i(6'h23, 5'd0, 5'd4, 16'h0008));
        put(enc_i(6'h2B, 5'd0, 5'd4, 16'h0304));
        put(ILL);
        expect_store(32'h8, 32'h55);
        expect_store(32'h304, 32'h55);
        go();
        run(400, 0);
        check("sw_wait_cycles", 32'(rc(1) - rc(0)), 32'd10);
        check("lw_wait_cycles", 32'(rc(2) - rc(1)), 32'd11);
        check("hold_stable", 32'(stab_err), 32'd0);
        sb_check("ldst");

        // Branches and jumps: retire PC sequence.
        begin_test(0);
        put(enc_i(6'h08, 5'd0, 5'd1, 16'd1));
        put(enc_i(6'h04, 5'd1, 5'd0, 16'd9));
        put(enc_j(26'd4));
        poke(32'h10, enc_i(6'h04, 5'd1, 5'd1, 16'hFFFE));
        poke(32'h0C, enc_j(26'd8));
        poke(32'h20, enc_j(26'h40));
        exp_pcs[0] = 32'h104; exp_pcs[1] = 32'h108; exp_pcs[2] = 32'h10;
        exp_pcs[3] = 32'h0C;  exp_pcs[4] = 32'h20;  exp_pcs[5] = 32'h100;
        go();
        run(200, 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("br_pc%0d", i), (i < ret_pc.size()) ? ret_pc[i] : 32'hXXXX_XXXX, exp_pcs[i]);
        check("beq_nt_cycles", 32'(rc(1) - rc(0)), 32'd3);
        check("beq_t_cycles", 32'(rc(3) - rc(2)), 32'd3);
        check("j_cycles", 32'(rc(4) - rc(3)), 32'd3);
        sb_check("branch");

        // ALU vector table.
        for (int v = 0; v < 9; v++) begin
            begin_test(v % 2);
            put(enc_i(6'h23, 5'd0, 5'd1, 16'h0200));
            put(enc_i(6'h23, 5'd0, 5'd2, 16'h0204));
            put(vecs[v].instr);
            put(enc_i(6'h2B, 5'd0, 5'd3, 16'h0208));
            put(ILL);
            poke(32'h200, vecs[v].a);
            poke(32'h204, vecs[v].b);
            expect_store(32'h208, vecs[v].exp);
            go();
            run(300, 0);
            sb_check($sformatf("alu%0d", v));
        end

        // R0 is hardwired to zero.
        begin_test(0);
        put(enc_i(6'h08, 5'd0, 5'd0, 16'd5));
        put(enc_i(6'h2B, 5'd0, 5'd0, 16'h020C));
        put(ILL);
        expect_store(32'h20C, 32'd0);
        go();
        run(100, 0);
        sb_check("r0");

        // Illegal opcode: sticky halt, no requests, reset clears.
        begin_test(0);
        put(ILL);
        go();
        run(50, 0);
        check("halt_cyc", 32'(halt_cyc), 32'd3);
        check("halt_no_retire", 32'(ret_cyc.size()), 32'd0);
        idle = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_req || retire || !halted) idle++;
        end
        check("halt_quiet", 32'(idle), 32'd0);
        rst = 1'b1;
        #1 check1("halt_rst_clear", halted, 1'b0);
        go();
        @(negedge clk);
        check1("halt_after_rst", halted, 1'b0);

        // Unknown R-type funct halts too.
        begin_test(0);
        put(enc_r(5'd1, 5'd2, 5'd3, 6'h21));
        go();
        run(50, 0);
        check("funct_halt_cyc", 32'(halt_cyc), 32'd3);

        // Pause: en dropped during WB holds the next fetch.
        begin_test(0);
        put(enc_i(6'h08, 5'd0, 5'd1, 16'd9));
        put(enc_i(6'h2B, 5'd0, 5'd1, 16'h0300));
        put(ILL);
        expect_store(32'h300, 32'd9);
        go();
        for (int i = 0; i < 20 && !retire; i++) @(negedge clk);
        check1("pause_wb_seen", retire, 1'b1);
        en = 1'b0;
        idle = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_req) idle++;
        end
        check("pause_no_req", 32'(idle), 32'd0);
        check("pause_pc", pc_out, 32'h104);
        en = 1'b1;
        #1;
        check1("resume_req", mem_req, 1'b1);
        check("resume_addr", mem_addr, 32'h104);
        run(100, 0);
        sb_check("pause");

        // Reset while a store waits for ready.
        begin_test(5);
        put(enc_i(6'h08, 5'd0, 5'd1, 16'd7));
        put(enc_i(6'h2B, 5'd0, 5'd1, 16'h0300));
        put(ILL);
        go();
        for (int i = 0; i < 80 && !(mem_req && mem_we); i++) @(negedge clk);
        check1("sw_req_seen", mem_req && mem_we, 1'b1);
        rst = 1'b1;
        en  = 1'b0;
        #1;
        check1("rst_abort_req", mem_req, 1'b0);
        check("rst_abort_pc", pc_out, RPC);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_abort_pc_held", pc_out, RPC);
        sb_check("rst_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
